// File: rtl/imem_loader_if.sv
// Byte-stream in / instruction-memory write-port out for the program loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_err;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Framed program-image loader: SYNC, LEN_LO, LEN_HI, data bytes, CSUM -> byte writes from addr 0.
// The CPU is held in reset until a frame's 8-bit additive checksum matches.
module imem_loader #(
    parameter int         ADDR_WIDTH = 5,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    localparam logic [16:0] DEPTH = 17'(2**ADDR_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_CHECK, ST_DONE, ST_ERR
    } state_t;

    state_t                r_state;
    logic                  r_rx_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [7:0]            r_mem_wdata;
    logic                  r_cpu_hold;
    logic                  r_load_done;
    logic                  r_load_err;
    logic [7:0]            r_len_lo;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [7:0]            r_sum;
    logic [7:0]            r_csum;

    logic                  w_acc;
    logic [15:0]           w_len;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;

    assign w_acc     = bus.rx_valid && r_rx_ready;
    assign w_len     = {bus.rx_data, r_len_lo};
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_csum      <= '0;
        end else begin
            r_mem_we   <= 1'b0;
            r_rx_ready <= 1'b1;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_acc && bus.rx_data == SYNC_BYTE) begin
                        r_state     <= ST_LEN_LO;
                        r_cpu_hold  <= 1'b1;
                        r_load_done <= 1'b0;
                        r_load_err  <= 1'b0;
                        r_cnt       <= '0;
                        r_sum       <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_acc) begin
                        r_len_lo <= bus.rx_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_acc) begin
                        r_len <= w_len[ADDR_WIDTH:0];
                        // Oversized images are rejected before any byte is written.
                        if ({1'b0, w_len} > DEPTH) begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_acc) begin
                        r_mem_we    <= 1'b1;
                        r_mem_waddr <= r_cnt[ADDR_WIDTH-1:0];
                        r_mem_wdata <= bus.rx_data;
                        r_cnt       <= w_cnt_nxt;
                        r_sum       <= r_sum + bus.rx_data;
                        if (w_cnt_nxt == r_len)
                            r_state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (w_acc) begin
                        r_csum     <= bus.rx_data;
                        r_state    <= ST_CHECK;
                        r_rx_ready <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (r_csum == r_sum) begin
                        r_state     <= ST_DONE;
                        r_load_done <= 1'b1;
                        r_cpu_hold  <= 1'b0;
                    end else begin
                        r_state    <= ST_ERR;
                        r_load_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.load_done = r_load_done;
    assign bus.load_err  = r_load_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are pushed byte-wise, writes captured on the falling edge.
module tb_imem_loader;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   lat_bad = 0;
    bit   prev_acc = 1'b0;
    logic [AW-1:0] wa[$];
    logic [7:0]    wd[$];

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
    imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa.push_back(bus.mem_waddr);
            wd.push_back(bus.mem_wdata);
            if (!prev_acc) lat_bad++;
        end
        prev_acc = bus.rx_valid && bus.rx_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        lat_bad = 0;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        int n;
        if (gaps) step($urandom_range(0, 2));
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        forever begin
            ok = bus.rx_ready;
            step(1);
            if (ok) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] d[$], input logic [7:0] cs, input bit gaps);
        int len;
        len = d.size();
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        foreach (d[i]) send_byte(d[i], gaps);
        send_byte(cs, gaps);
    endtask

    task automatic finish_frame(input string tag, input bit ok);
        chk({tag, "_check_rdy"}, bus.rx_ready, 0);
        step(1);
        chk({tag, "_done"}, bus.load_done, ok);
        chk({tag, "_err"},  bus.load_err, !ok);
        chk({tag, "_hold"}, bus.cpu_hold, !ok);
        chk({tag, "_rdy"},  bus.rx_ready, 1);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] d[$]);
        chk({tag, "_nwr"}, wa.size(), d.size());
        if (wa.size() == d.size())
            foreach (d[i]) begin
                chk({tag, "_addr"}, wa[i], i);
                chk({tag, "_data"}, wd[i], d[i]);
            end
        chk({tag, "_lat"}, lat_bad, 0);
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] big[$];
        logic [7:0] none[$];
        logic [7:0] wd_ref[$];
        logic [AW-1:0] wa_ref[$];
        prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        for (int i = 0; i < 32; i++) big.push_back(8'(i * 7 + 3));

        // Reset state
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        step(3);
        chk("rst_rdy", bus.rx_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_waddr", bus.mem_waddr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_done", bus.load_done, 0);
        chk("rst_err", bus.load_err, 0);
        rst_n = 1'b1;
        step(1);
        chk("rel_rdy", bus.rx_ready, 1);
        step(10);
        chk("idle_nwr", wa.size(), 0);
        chk("idle_hold", bus.cpu_hold, 1);
        chk("idle_done", bus.load_done, 0);
        chk("idle_err", bus.load_err, 0);

        // Good 8-byte frame, data sum = 0xE0
        clear_log();
        send_byte(8'hA5, 0);
        send_body(prog, 8'hE0, 0);
        finish_frame("t2", 1);
        check_writes("t2", prog);

        // Same frame, checksum off by one; reload clears done/releases nothing
        clear_log();
        send_byte(8'hA5, 0);
        chk("t3_sync_hold", bus.cpu_hold, 1);
        chk("t3_sync_done", bus.load_done, 0);
        send_body(prog, 8'hE1, 0);
        finish_frame("t3", 0);
        check_writes("t3", prog);

        // Oversized length rejected right after LEN_HI
        clear_log();
        send_byte(8'hA5, 0);
        send_byte(8'h21, 0);
        send_byte(8'h00, 0);
        chk("t4a_err", bus.load_err, 1);
        chk("t4a_done", bus.load_done, 0);
        chk("t4a_hold", bus.cpu_hold, 1);
        step(3);
        chk("t4a_nwr", wa.size(), 0);

        // Exactly full memory: sum of (7i+3), i=0..31 = 0xDF0 -> 0xF0
        clear_log();
        send_byte(8'hA5, 0);
        send_body(big, 8'hF0, 0);
        finish_frame("t4b", 1);
        check_writes("t4b", big);

        // Garbage ignored in DONE, then zero-length frame
        clear_log();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        chk("t5_garbage_done", bus.load_done, 1);
        chk("t5_garbage_hold", bus.cpu_hold, 0);
        send_byte(8'hA5, 0);
        send_body(none, 8'h00, 0);
        finish_frame("t5", 1);
        chk("t5_nwr", wa.size(), 0);

        // Reset mid-frame, then a gapped reload must give identical writes
        clear_log();
        send_byte(8'hA5, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) send_byte(prog[i], 0);
        step(1);
        chk("t6_partial_nwr", wa.size(), 3);
        rst_n = 1'b0;
        step(2);
        chk("t6_rst_rdy", bus.rx_ready, 0);
        chk("t6_rst_hold", bus.cpu_hold, 1);
        chk("t6_rst_done", bus.load_done, 0);
        chk("t6_rst_waddr", bus.mem_waddr, 0);
        rst_n = 1'b1;
        step(1);
        clear_log();
        send_byte(8'hA5, 1);
        send_body(prog, 8'hE0, 1);
        finish_frame("t6", 1);
        check_writes("t6", prog);
        wa_ref = wa;
        wd_ref = wd;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
